// File: rtl/dbg_axi_bridge_if.sv
// Signal bundles for dbg_axi_bridge: the debug (LMon) bus and the AXI master port.
// Signal names keep their bridge-relative i/o prefixes so existing hookups carry over.
interface dbg_bus_if #(
    parameter int unsigned LEN_WIDTH = 5
);
    logic                 iDSel;
    logic [31:0]          iDAddr;
    logic [31:0]          iDData;
    logic [LEN_WIDTH-1:0] iDLen;
    logic                 iDLMonWen;
    logic                 iDLMonRen;
    logic [31:0]          oDLMonRD;
    logic                 oDRdy;

    modport master (
        output iDSel, iDAddr, iDData, iDLen, iDLMonWen, iDLMonRen,
        input  oDLMonRD, oDRdy
    );
    modport slave (
        input  iDSel, iDAddr, iDData, iDLen, iDLMonWen, iDLMonRen,
        output oDLMonRD, oDRdy
    );
endinterface

interface dbg_axi_if;
    logic [31:0] oAWADDR;
    logic        oAWVALID;
    logic        iAWREADY;
    logic [31:0] oWDATA;
    logic        oWVALID;
    logic        iWREADY;
    logic [1:0]  iBRESP;
    logic        iBVALID;
    logic        oBREADY;
    logic [31:0] oARADDR;
    logic [3:0]  oARLEN;
    logic        oARVALID;
    logic        iARREADY;
    logic [31:0] iRDATA;
    logic [1:0]  iRRESP;
    logic        iRLAST;
    logic        iRVALID;
    logic        oRREADY;

    modport master (
        output oAWADDR, oAWVALID, oWDATA, oWVALID, oBREADY,
               oARADDR, oARLEN, oARVALID, oRREADY,
        input  iAWREADY, iWREADY, iBRESP, iBVALID,
               iARREADY, iRDATA, iRRESP, iRLAST, iRVALID
    );
    modport slave (
        input  oAWADDR, oAWVALID, oWDATA, oWVALID, oBREADY,
               oARADDR, oARLEN, oARVALID, oRREADY,
        output iAWREADY, iWREADY, iBRESP, iBVALID,
               iARREADY, iRDATA, iRRESP, iRLAST, iRVALID
    );
endinterface

// File: rtl/dbg_axi_bridge.sv
// Debug LMon bus to AXI master bridge: single writes, INCR read bursts up to MAX_BURST beats.
// Define DBG_AXI_RESP_CHK_EN to latch non-OKAY BRESP/RRESP into the sticky oErr flag.
module dbg_axi_bridge #(
    parameter int unsigned LEN_WIDTH = 5,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic       iSoCClk,
    input  logic       iSoCRst,
    dbg_bus_if.slave   dbg,
    dbg_axi_if.master  axi,
    output logic       oErr
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} bridgeState_t;

    bridgeState_t state;
    logic [3:0]   arLenNext;
    logic         awDone;
    logic         wDone;

    // Zero-length requests read one beat; oversize requests are clamped.
    always_comb begin
        arLenNext = '0;
        if (32'(dbg.iDLen) > MAX_BURST) begin
            arLenNext = 4'(MAX_BURST - 1);
        end else if (dbg.iDLen != '0) begin
            arLenNext = 4'(32'(dbg.iDLen) - 1);
        end
    end

    always_comb begin
        awDone = !axi.oAWVALID || axi.iAWREADY;
        wDone  = !axi.oWVALID  || axi.iWREADY;
    end

    always_ff @(posedge iSoCClk or posedge iSoCRst) begin
        if (iSoCRst) begin
            state        <= IDLE;
            axi.oAWADDR  <= '0;
            axi.oAWVALID <= 1'b0;
            axi.oWDATA   <= '0;
            axi.oWVALID  <= 1'b0;
            axi.oBREADY  <= 1'b0;
            axi.oARADDR  <= '0;
            axi.oARLEN   <= '0;
            axi.oARVALID <= 1'b0;
            axi.oRREADY  <= 1'b0;
            dbg.oDLMonRD <= '0;
            dbg.oDRdy    <= 1'b0;
        end else begin
            dbg.oDRdy <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dbg.iDSel && dbg.iDLMonWen) begin
                        axi.oAWADDR  <= dbg.iDAddr;
                        axi.oWDATA   <= dbg.iDData;
                        axi.oAWVALID <= 1'b1;
                        axi.oWVALID  <= 1'b1;
                        state        <= WADDR;
                    end else if (dbg.iDSel && dbg.iDLMonRen) begin
                        axi.oARADDR  <= dbg.iDAddr;
                        axi.oARLEN   <= arLenNext;
                        axi.oARVALID <= 1'b1;
                        state        <= RADDR;
                    end
                end
                WADDR: begin
                    // AW and W complete independently; leave once neither is outstanding.
                    if (axi.oAWVALID && axi.iAWREADY) axi.oAWVALID <= 1'b0;
                    if (axi.oWVALID && axi.iWREADY)   axi.oWVALID  <= 1'b0;
                    if (awDone && wDone) begin
                        axi.oBREADY <= 1'b1;
                        state       <= WRESP;
                    end
                end
                WRESP: begin
                    if (axi.iBVALID) begin
                        axi.oBREADY <= 1'b0;
                        dbg.oDRdy   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                RADDR: begin
                    if (axi.iARREADY) begin
                        axi.oARVALID <= 1'b0;
                        axi.oRREADY  <= 1'b1;
                        state        <= RDATA;
                    end
                end
                RDATA: begin
                    if (axi.iRVALID) begin
                        dbg.oDLMonRD <= axi.iRDATA;
                        dbg.oDRdy    <= 1'b1;
                        if (axi.iRLAST) begin
                            axi.oRREADY <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DBG_AXI_RESP_CHK_EN
    always_ff @(posedge iSoCClk or posedge iSoCRst) begin
        if (iSoCRst) begin
            oErr <= 1'b0;
        end else if ((state == WRESP && axi.iBVALID && axi.iBRESP != 2'b00) ||
                     (state == RDATA && axi.iRVALID && axi.iRRESP != 2'b00)) begin
            oErr <= 1'b1;
        end
    end
`else
    logic unusedResp;
    assign unusedResp = ^{axi.iBRESP, axi.iRRESP};
    assign oErr       = 1'b0;
`endif
endmodule

// File: tb/tb_dbg_axi_bridge.sv
// Directed self-checking bench for dbg_axi_bridge; inputs change and outputs are sampled on negedge.
module tb_dbg_axi_bridge;
    localparam int unsigned LW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    always #5 clk = ~clk;

    dbg_bus_if #(.LEN_WIDTH(LW)) dbg ();
    dbg_axi_if axi ();

    dbg_axi_bridge #(.LEN_WIDTH(LW), .MAX_BURST(16)) dut (
        .iSoCClk (clk),
        .iSoCRst (rst),
        .dbg     (dbg),
        .axi     (axi),
        .oErr    (err)
    );

    int total = 0;
    int bad   = 0;
    int awHs  = 0;
    int wHs   = 0;
    int arHs  = 0;
    int rdyCnt = 0;

    always @(posedge clk) begin
        if (axi.oAWVALID && axi.iAWREADY) awHs++;
        if (axi.oWVALID && axi.iWREADY)   wHs++;
        if (axi.oARVALID && axi.iARREADY) arHs++;
        if (dbg.oDRdy)                    rdyCnt++;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clearInputs;
        dbg.iDSel = 0; dbg.iDAddr = '0; dbg.iDData = '0; dbg.iDLen = '0;
        dbg.iDLMonWen = 0; dbg.iDLMonRen = 0;
        axi.iAWREADY = 0; axi.iWREADY = 0; axi.iBRESP = '0; axi.iBVALID = 0;
        axi.iARREADY = 0; axi.iRDATA = '0; axi.iRRESP = '0; axi.iRLAST = 0; axi.iRVALID = 0;
    endtask

    // Full write with ready slave; returns on the negedge where oDRdy should be high.
    task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        axi.iAWREADY = 1; axi.iWREADY = 1;
        dbg.iDSel = 1; dbg.iDLMonWen = 1; dbg.iDAddr = a; dbg.iDData = d;
        tick;
        dbg.iDSel = 0; dbg.iDLMonWen = 0;
        tick;
        axi.iAWREADY = 0; axi.iWREADY = 0;
        axi.iBVALID = 1; axi.iBRESP = resp;
        tick;
        axi.iBVALID = 0; axi.iBRESP = '0;
    endtask

    // One-beat read; returns on the negedge where oDRdy/oDLMonRD should show the beat.
    task automatic doRead1(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        dbg.iDSel = 1; dbg.iDLMonRen = 1; dbg.iDAddr = a; dbg.iDLen = 5'd1;
        tick;
        dbg.iDSel = 0; dbg.iDLMonRen = 0;
        axi.iARREADY = 1;
        tick;
        axi.iARREADY = 0;
        axi.iRVALID = 1; axi.iRLAST = 1; axi.iRDATA = d; axi.iRRESP = resp;
        tick;
        axi.iRVALID = 0; axi.iRLAST = 0; axi.iRRESP = '0;
    endtask

    task automatic test_reset;
        logic [6:0] flags;
        tick;
        flags = {axi.oAWVALID, axi.oWVALID, axi.oBREADY, axi.oARVALID, axi.oRREADY, dbg.oDRdy, err};
        total++; if (flags !== 7'b0) begin bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 7'b0); end
        total++; if ({axi.oAWADDR, axi.oWDATA} !== 64'h0) begin bad++; $display("FAIL reset_aw_w got=%h exp=0", {axi.oAWADDR, axi.oWDATA}); end
        total++; if ({axi.oARADDR, axi.oARLEN} !== 36'h0) begin bad++; $display("FAIL reset_ar got=%h exp=0", {axi.oARADDR, axi.oARLEN}); end
        total++; if (dbg.oDLMonRD !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", dbg.oDLMonRD); end
        rst = 0;
        tick;
    endtask

    task automatic test_write_basic;
        int a0 = awHs; int w0 = wHs; int r0 = rdyCnt;
        axi.iAWREADY = 1; axi.iWREADY = 1;
        dbg.iDSel = 1; dbg.iDLMonWen = 1; dbg.iDAddr = 32'h1000_0040; dbg.iDData = 32'hDEAD_BEEF;
        tick;
        dbg.iDSel = 0; dbg.iDLMonWen = 0;
        total++; if ({axi.oAWVALID, axi.oWVALID} !== 2'b11) begin bad++; $display("FAIL wr_valids got=%b exp=11", {axi.oAWVALID, axi.oWVALID}); end
        total++; if (axi.oAWADDR !== 32'h1000_0040) begin bad++; $display("FAIL wr_awaddr got=%h exp=10000040", axi.oAWADDR); end
        total++; if (axi.oWDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_wdata got=%h exp=deadbeef", axi.oWDATA); end
        tick;
        axi.iAWREADY = 0; axi.iWREADY = 0;
        total++; if ({axi.oAWVALID, axi.oWVALID, axi.oBREADY} !== 3'b001) begin bad++; $display("FAIL wr_bready got=%b exp=001", {axi.oAWVALID, axi.oWVALID, axi.oBREADY}); end
        total++; if (dbg.oDRdy !== 1'b0) begin bad++; $display("FAIL wr_rdy_early got=%b exp=0", dbg.oDRdy); end
        axi.iBVALID = 1;
        tick;
        axi.iBVALID = 0;
        total++; if ({dbg.oDRdy, axi.oBREADY} !== 2'b10) begin bad++; $display("FAIL wr_rdy_pulse got=%b exp=10", {dbg.oDRdy, axi.oBREADY}); end
        tick;
        total++; if (dbg.oDRdy !== 1'b0) begin bad++; $display("FAIL wr_rdy_end got=%b exp=0", dbg.oDRdy); end
        total++; if ({awHs - a0, wHs - w0, rdyCnt - r0} !== {32'd1, 32'd1, 32'd1}) begin
            bad++; $display("FAIL wr_counts got=%0d/%0d/%0d exp=1/1/1", awHs - a0, wHs - w0, rdyCnt - r0);
        end
    endtask

    task automatic test_write_wready_first;
        int r0 = rdyCnt; int a0 = awHs;
        dbg.iDSel = 1; dbg.iDLMonWen = 1; dbg.iDAddr = 32'h2000_0000; dbg.iDData = 32'h1234_5678;
        tick;
        dbg.iDSel = 0; dbg.iDLMonWen = 0;
        axi.iWREADY = 1;
        tick;
        axi.iWREADY = 0;
        total++; if ({axi.oAWVALID, axi.oWVALID} !== 2'b10) begin bad++; $display("FAIL wf_wdrop got=%b exp=10", {axi.oAWVALID, axi.oWVALID}); end
        for (int i = 0; i < 2; i++) begin
            tick;
            total++; if ({axi.oAWVALID, axi.oWVALID, axi.oBREADY} !== 3'b100) begin
                bad++; $display("FAIL wf_awhold got=%b exp=100", {axi.oAWVALID, axi.oWVALID, axi.oBREADY});
            end
        end
        axi.iAWREADY = 1;
        tick;
        axi.iAWREADY = 0;
        total++; if ({axi.oAWVALID, axi.oBREADY} !== 2'b01) begin bad++; $display("FAIL wf_wresp got=%b exp=01", {axi.oAWVALID, axi.oBREADY}); end
        axi.iBVALID = 1;
        tick;
        axi.iBVALID = 0;
        repeat (3) tick;
        total++; if ({rdyCnt - r0, awHs - a0} !== {32'd1, 32'd1}) begin
            bad++; $display("FAIL wf_counts got=%0d/%0d exp=1/1", rdyCnt - r0, awHs - a0);
        end
    endtask

    task automatic test_read_len4;
        logic [31:0] data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        int          gaps [4] = '{2, 0, 1, 0};
        int r0 = rdyCnt;
        dbg.iDSel = 1; dbg.iDLMonRen = 1; dbg.iDAddr = 32'h3000_0100; dbg.iDLen = 5'd4;
        tick;
        dbg.iDSel = 0; dbg.iDLMonRen = 0;
        total++; if ({axi.oARVALID, axi.oARLEN} !== 5'b1_0011) begin bad++; $display("FAIL rd_arlen got=%b exp=10011", {axi.oARVALID, axi.oARLEN}); end
        total++; if (axi.oARADDR !== 32'h3000_0100) begin bad++; $display("FAIL rd_araddr got=%h exp=30000100", axi.oARADDR); end
        tick;
        total++; if ({axi.oARVALID, axi.oRREADY} !== 2'b10) begin bad++; $display("FAIL rd_arhold got=%b exp=10", {axi.oARVALID, axi.oRREADY}); end
        axi.iARREADY = 1;
        tick;
        axi.iARREADY = 0;
        total++; if ({axi.oARVALID, axi.oRREADY} !== 2'b01) begin bad++; $display("FAIL rd_rready got=%b exp=01", {axi.oARVALID, axi.oRREADY}); end
        for (int i = 0; i < 4; i++) begin
            axi.iRVALID = 1; axi.iRDATA = data[i]; axi.iRLAST = (i == 3);
            tick;
            axi.iRVALID = 0; axi.iRLAST = 0;
            total++; if ({dbg.oDRdy, dbg.oDLMonRD} !== {1'b1, data[i]}) begin
                bad++; $display("FAIL rd_beat%0d got=%b/%h exp=1/%h", i, dbg.oDRdy, dbg.oDLMonRD, data[i]);
            end
            for (int g = 0; g < gaps[i]; g++) begin
                tick;
                total++; if (dbg.oDRdy !== 1'b0) begin bad++; $display("FAIL rd_gap%0d got=%b exp=0", i, dbg.oDRdy); end
            end
        end
        total++; if (axi.oRREADY !== 1'b0) begin bad++; $display("FAIL rd_done got=%b exp=0", axi.oRREADY); end
        tick;
        total++; if (rdyCnt - r0 !== 4) begin bad++; $display("FAIL rd_pulses got=%0d exp=4", rdyCnt - r0); end
    endtask

    task automatic test_len_clamp;
        logic [LW-1:0] lens [5] = '{5'd0, 5'd1, 5'd16, 5'd20, 5'd31};
        logic [3:0]    exps [5] = '{4'd0, 4'd0, 4'd15, 4'd15, 4'd15};
        for (int i = 0; i < 5; i++) begin
            dbg.iDSel = 1; dbg.iDLMonRen = 1; dbg.iDAddr = 32'h4000_0000; dbg.iDLen = lens[i];
            tick;
            dbg.iDSel = 0; dbg.iDLMonRen = 0;
            total++; if (axi.oARLEN !== exps[i]) begin bad++; $display("FAIL clamp_len%0d got=%0d exp=%0d", lens[i], axi.oARLEN, exps[i]); end
            axi.iARREADY = 1;
            tick;
            axi.iARREADY = 0;
            axi.iRVALID = 1; axi.iRLAST = 1; axi.iRDATA = 32'(i);
            tick;
            axi.iRVALID = 0; axi.iRLAST = 0;
            tick;
        end
    endtask

    task automatic test_wen_ren;
        int a0 = awHs; int ar0 = arHs;
        dbg.iDSel = 1; dbg.iDLMonWen = 1; dbg.iDLMonRen = 1; dbg.iDAddr = 32'h5000_0000; dbg.iDLen = 5'd4;
        tick;
        dbg.iDSel = 0; dbg.iDLMonWen = 0; dbg.iDLMonRen = 0;
        total++; if ({axi.oAWVALID, axi.oARVALID} !== 2'b10) begin bad++; $display("FAIL both_sel got=%b exp=10", {axi.oAWVALID, axi.oARVALID}); end
        axi.iAWREADY = 1; axi.iWREADY = 1;
        tick;
        axi.iAWREADY = 0; axi.iWREADY = 0; axi.iBVALID = 1;
        tick;
        axi.iBVALID = 0;
        repeat (2) tick;
        total++; if ({awHs - a0, arHs - ar0} !== {32'd1, 32'd0}) begin
            bad++; $display("FAIL both_counts got=%0d/%0d exp=1/0", awHs - a0, arHs - ar0);
        end
        total++; if (axi.oARVALID !== 1'b0) begin bad++; $display("FAIL both_noar got=%b exp=0", axi.oARVALID); end
    endtask

    task automatic test_ignore;
        int ar0 = arHs;
        dbg.iDSel = 0; dbg.iDLMonWen = 1; dbg.iDAddr = 32'h6000_0000;
        tick;
        dbg.iDLMonWen = 0;
        total++; if (axi.oAWVALID !== 1'b0) begin bad++; $display("FAIL nosel got=%b exp=0", axi.oAWVALID); end
        dbg.iDSel = 1; dbg.iDLMonWen = 1;
        tick;
        dbg.iDLMonWen = 0; dbg.iDLMonRen = 1;
        tick;
        dbg.iDSel = 0; dbg.iDLMonRen = 0;
        axi.iAWREADY = 1; axi.iWREADY = 1;
        tick;
        axi.iAWREADY = 0; axi.iWREADY = 0; axi.iBVALID = 1;
        tick;
        axi.iBVALID = 0;
        repeat (2) tick;
        total++; if ({axi.oARVALID, axi.oAWVALID, 32'(arHs - ar0)} !== 34'h0) begin
            bad++; $display("FAIL busy_drop got=%b/%b/%0d exp=0/0/0", axi.oARVALID, axi.oAWVALID, arHs - ar0);
        end
    endtask

    task automatic test_reset_mid;
        dbg.iDSel = 1; dbg.iDLMonRen = 1; dbg.iDAddr = 32'h7000_0000; dbg.iDLen = 5'd2;
        tick;
        dbg.iDSel = 0; dbg.iDLMonRen = 0; axi.iARREADY = 1;
        tick;
        axi.iARREADY = 0; axi.iRVALID = 1; axi.iRDATA = 32'h99;
        tick;
        axi.iRVALID = 0;
        total++; if ({axi.oRREADY, dbg.oDRdy} !== 2'b11) begin bad++; $display("FAIL mid_pre got=%b exp=11", {axi.oRREADY, dbg.oDRdy}); end
        #2 rst = 1;
        #1;
        total++; if ({axi.oAWVALID, axi.oWVALID, axi.oBREADY, axi.oARVALID, axi.oRREADY, dbg.oDRdy} !== 6'b0) begin
            bad++; $display("FAIL mid_async got=%b exp=000000",
                {axi.oAWVALID, axi.oWVALID, axi.oBREADY, axi.oARVALID, axi.oRREADY, dbg.oDRdy});
        end
        tick;
        rst = 0;
        tick;
        doRead1(32'h7000_0010, 32'hA5A5_0001, 2'b00);
        total++; if ({dbg.oDRdy, dbg.oDLMonRD, axi.oRREADY} !== {1'b1, 32'hA5A5_0001, 1'b0}) begin
            bad++; $display("FAIL mid_after got=%b/%h/%b exp=1/a5a50001/0", dbg.oDRdy, dbg.oDLMonRD, axi.oRREADY);
        end
        tick;
    endtask

    task automatic test_err;
        doWrite(32'h8000_0000, 32'h0, 2'b10);
`ifdef DBG_AXI_RESP_CHK_EN
        total++; if ({dbg.oDRdy, err} !== 2'b11) begin bad++; $display("FAIL err_set got=%b exp=11", {dbg.oDRdy, err}); end
        tick;
        doRead1(32'h8000_0004, 32'h55, 2'b00);
        total++; if ({dbg.oDRdy, err} !== 2'b11) begin bad++; $display("FAIL err_sticky got=%b exp=11", {dbg.oDRdy, err}); end
        rst = 1;
        tick;
        rst = 0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
`else
        total++; if ({dbg.oDRdy, err} !== 2'b10) begin bad++; $display("FAIL err_off_w got=%b exp=10", {dbg.oDRdy, err}); end
        tick;
        doRead1(32'h8000_0004, 32'h55, 2'b11);
        total++; if ({dbg.oDRdy, err} !== 2'b10) begin bad++; $display("FAIL err_off_r got=%b exp=10", {dbg.oDRdy, err}); end
`endif
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clearInputs;
        test_reset;
        test_write_basic;
        test_write_wready_first;
        test_read_len4;
        test_len_clamp;
        test_wen_ren;
        test_ignore;
        test_reset_mid;
        test_err;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
